// File: rtl/seq_add_sub_unit_pkg.sv
// Shared definitions for the multi-cycle add/subtract unit: function codes,
// FSM state encodings, flag bundle and a small sizing helper.
package seq_add_sub_unit_pkg;

    // ALU function codes; anything other than FUNC_ADD subtracts.
    localparam logic [3:0] FUNC_ADD = 4'h0;
    localparam logic [3:0] FUNC_SUB = 4'h1;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Result flag bundle.
    typedef struct packed {
        logic ovf;
        logic carry;
        logic zero;
    } flags_t;

    // Width of the chunk index counter; at least one bit even when N = 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_add_sub_unit_chunk_adder.sv
// One chunk of the ripple sum: W-bit add with carry in, exposing the carry
// out of the chunk and the carry into its top bit for overflow detection.
module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] full_sum;

    // Plain W+1 bit addition; the carry into the top bit is recovered from the
    // top sum bit, which avoids a separate (W-1)-bit adder and works for W = 1.
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sum      = full_sum[W-1:0];
        cout     = full_sum[W];
        c_msb    = full_sum[W-1] ^ a[W-1] ^ b[W-1];
    end

endmodule

// File: rtl/seq_add_sub_unit.sv
// Multi-cycle add/subtract unit. Operands are summed CHUNK_WIDTH bits per
// cycle, LSB chunk first, with valid/ready handshakes on both sides.
// DATA_WIDTH must be a multiple of CHUNK_WIDTH.
module seq_add_sub_unit
    import seq_add_sub_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            FuncCode,
    input  logic                  sat_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] C,
    output logic                  OverflowFlag,
    output logic                  CarryFlag,
    output logic                  ZeroFlag
);

    localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Clamp to the signed extreme on the side of A's sign when enabled.
    function automatic logic [DATA_WIDTH-1:0] saturate(
        input logic [DATA_WIDTH-1:0] raw,
        input logic                  ovf,
        input logic                  sat,
        input logic                  a_msb
    );
        logic signed [DATA_WIDTH-1:0] max_pos;
        logic signed [DATA_WIDTH-1:0] min_neg;
        max_pos                 = '1;
        max_pos[DATA_WIDTH-1]   = 1'b0;
        min_neg                 = '0;
        min_neg[DATA_WIDTH-1]   = 1'b1;
        if (sat && ovf) begin
            return a_msb ? min_neg : max_pos;
        end
        return raw;
    endfunction

    // Control state
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;

    // Captured request (data, not reset)
    logic signed [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0]        b_q, b_d;
    logic                         sub_q, sub_d;
    logic                         sat_q, sat_d;
    logic [DATA_WIDTH-1:0]        res_q, res_d;

    // Visible result and flags
    logic [DATA_WIDTH-1:0] c_q, c_d;
    flags_t                flags_q, flags_d;

    // Chunk datapath
    int                    chunk_base;
    logic [CHUNK_WIDTH-1:0] a_chunk;
    logic [CHUNK_WIDTH-1:0] b_chunk;
    logic [CHUNK_WIDTH-1:0] sum_chunk;
    logic                   cout_chunk;
    logic                   cmsb_chunk;
    logic                   ovf_now;

    // Select the operand chunk addressed by the index counter.
    always_comb begin
        chunk_base = int'(idx_q) * CHUNK_WIDTH;
        a_chunk    = a_q[chunk_base +: CHUNK_WIDTH];
        b_chunk    = b_q[chunk_base +: CHUNK_WIDTH];
    end

    chunk_adder #(
        .W (CHUNK_WIDTH)
    ) u_chunk_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .sum   (sum_chunk),
        .cout  (cout_chunk),
        .c_msb (cmsb_chunk)
    );

    assign ovf_now = cmsb_chunk ^ cout_chunk;

    // Next-state logic: capture in IDLE, one chunk per CALC cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sat_d   = sat_q;
        res_d   = res_q;
        c_d     = c_q;
        flags_d = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B once here, seed carry with 1.
                    sub_d   = (FuncCode != FUNC_ADD);
                    a_d     = A;
                    b_d     = (FuncCode != FUNC_ADD) ? ~B : B;
                    sat_d   = sat_en;
                    carry_d = (FuncCode != FUNC_ADD);
                    idx_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                res_d[chunk_base +: CHUNK_WIDTH] = sum_chunk;
                carry_d = cout_chunk;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // Final chunk: its top bit is the word MSB, so flags come from here.
                    flags_d.ovf   = ovf_now;
                    flags_d.carry = sub_q ? ~cout_chunk : cout_chunk;
                    c_d           = saturate(res_d, ovf_now, sat_q, a_q[DATA_WIDTH-1]);
                    flags_d.zero  = (c_d == '0);
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, visible result and flags: cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

    // Operand and partial-result storage: always rewritten before use.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sub_q <= sub_d;
        sat_q <= sat_d;
        res_q <= res_d;
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign C            = c_q;
    assign OverflowFlag = flags_q.ovf;
    assign CarryFlag    = flags_q.carry;
    assign ZeroFlag     = flags_q.zero;

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// Directed bench for seq_add_sub_unit (16-bit operands, 4-bit chunks).
module tb_seq_add_sub_unit;
    import seq_add_sub_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  FuncCode = '0;
    logic        sat_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] C;
    logic        OverflowFlag;
    logic        CarryFlag;
    logic        ZeroFlag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  func;
        logic        sat;
        logic [15:0] c;
        logic        ovf;
        logic        cf;
        logic        zf;
    } vec_t;

    vec_t vecs[11];

    seq_add_sub_unit #(
        .DATA_WIDTH  (16),
        .CHUNK_WIDTH (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (A),
        .B            (B),
        .FuncCode     (FuncCode),
        .sat_en       (sat_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .C            (C),
        .OverflowFlag (OverflowFlag),
        .CarryFlag    (CarryFlag),
        .ZeroFlag     (ZeroFlag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and let it be accepted on the next posedge,
    // then scramble the inputs to show the captured copy is independent.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] func, input logic sat);
        @(negedge clk);
        A = a; B = b; FuncCode = func; sat_en = sat; in_valid = 1'b1;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = ~a; B = ~b; FuncCode = ~func; sat_en = ~sat;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic check_result(input vec_t v, input int edges);
        check({v.name, "_latency"}, edges, 32'd4);
        check({v.name, "_C"}, {16'd0, C}, {16'd0, v.c});
        check({v.name, "_ovf"}, {31'd0, OverflowFlag}, {31'd0, v.ovf});
        check({v.name, "_cf"}, {31'd0, CarryFlag}, {31'd0, v.cf});
        check({v.name, "_zf"}, {31'd0, ZeroFlag}, {31'd0, v.zf});
        check({v.name, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    endtask

    // Complete the output handshake; unit must be back in IDLE next cycle.
    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int edges;
        start_op(v.a, v.b, v.func, v.sat);
        wait_done(edges);
        check_result(v, edges);
        release_out();
    endtask

    initial begin
        int   edges;
        vec_t v;
        logic [15:0] held_c;

        vecs[0]  = '{"add_basic",    16'h1234, 16'h0FF0, FUNC_ADD, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"add_ovf",      16'h7FFF, 16'h0001, FUNC_ADD, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"add_ovf_sat",  16'h7FFF, 16'h0001, FUNC_ADD, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"sub_ovf",      16'h8000, 16'h0001, FUNC_SUB, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"sub_ovf_sat",  16'h8000, 16'h0001, FUNC_SUB, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"sub_borrow",   16'h0000, 16'h0001, FUNC_SUB, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{"sub_zero",     16'h5A5A, 16'h5A5A, FUNC_SUB, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{"sub_zero_fF",  16'h5A5A, 16'h5A5A, 4'hF,     1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{"add_wrap",     16'hFFFF, 16'h0001, FUNC_ADD, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{"add_neg_sat",  16'h8000, 16'h8000, FUNC_ADD, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{"sub_pos_sat",  16'h0001, 16'h8000, FUNC_SUB, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_C", {16'd0, C}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_flags", {29'd0, OverflowFlag, CarryFlag, ZeroFlag}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: DONE held, new requests ignored
        v = '{"bp", 16'h1234, 16'h0FF0, FUNC_ADD, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0};
        start_op(v.a, v.b, v.func, v.sat);
        wait_done(edges);
        check_result(v, edges);
        held_c = C;
        for (int k = 0; k < 3; k++) begin
            A = 16'hFFFF; B = 16'hFFFF; FuncCode = FUNC_ADD; sat_en = 1'b0;
            in_valid = (k != 1);
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_C_stable", {16'd0, C}, {16'd0, held_c});
            check("bp_flags_stable", {29'd0, OverflowFlag, CarryFlag, ZeroFlag}, 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        v = '{"after_bp", 16'h0100, 16'h0003, FUNC_SUB, 1'b0, 16'h00FD, 1'b0, 1'b0, 1'b0};
        run_vec(v);

        // Reset during the second CALC cycle
        start_op(16'h1111, 16'h2222, FUNC_ADD, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_C", {16'd0, C}, 32'd0);
        check("midrst_flags", {29'd0, OverflowFlag, CarryFlag, ZeroFlag}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst_hold_out_valid", {31'd0, out_valid}, 32'd0);
            if (k == 2) reset_n = 1'b1;
        end
        check("midrst_C_after", {16'd0, C}, 32'd0);
        v = '{"post_rst", 16'h0001, 16'h0001, FUNC_ADD, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
